beta_prefetch_fetch_unit: RTL and testbench
===========================================

// Module: beta_prefetch_fetch_unit
// PURPOSE
//  Pipelined successor fetch unit: keeps up to MaxOutstanding imem requests in flight and buffers
//  returned instructions in a FifoDepth-entry prefetch FIFO, giving 1 instr/cycle throughput.
//  Owns the sequential fetch address (BootAddr after reset, redirected by flush). Sits between
//  imem (req/ready/valid/rdata) and the IF stage, which pops via valid/ack.
// PARAMETERS
//  DataWidth       32            instruction/data width; address step = DataWidth/8
//  AddrWidth       32            fetch address width
//  FifoDepth       4             prefetch FIFO entries; power of 2, >=2
//  MaxOutstanding  2             max granted-but-unanswered requests; 1..FifoDepth
//  BootAddr        32'h0000_0000 fetch address after reset
// PORTS
//  clk_i               in   1          clock
//  rstn_i              in   1          reset, asynchronous, active-low
//  if_fu_fetch_en_i    in   1          permit new requests
//  if_fu_flush_i       in   1          redirect: discard buffered/in-flight, restart at flush_addr
//  if_fu_flush_addr_i  in   AddrWidth  redirect target
//  if_fu_instr_req_o   out  1          imem request
//  if_fu_instr_addr_o  out  AddrWidth  imem request address
//  if_fu_instr_ready_i in   1          imem grant (req & ready = accepted)
//  if_fu_instr_valid_i in   1          imem response valid (in order, 1 cycle each)
//  if_fu_instr_rdata_i in   DataWidth  imem response data
//  if_fu_instr_o       out  DataWidth  FIFO head; 32'h00000013 (NOP) when empty
//  if_fu_instr_pc_o    out  AddrWidth  address of FIFO head
//  if_fu_new_instr_o   out  1          head valid (FIFO non-empty)
//  if_fu_instr_ack_i   in   1          consumer pops head (ignored when empty)
//  if_fu_stage_busy_o  out  1          outstanding != 0 or state == DRAIN
// BEHAVIOUR
//  Reset (async, rstn_i low): req_o=0, addr_o=BootAddr, FIFO empty, new_instr_o=0,
//   instr_o=NOP, pc_o=0, busy_o=0, outstanding=0, state=IDLE.
//  FSM: IDLE  -> FETCH when fetch_en_i; FETCH -> IDLE when !fetch_en_i and req not pending;
//   any state -> DRAIN on flush_i if outstanding after this cycle >0, else -> FETCH/IDLE per fetch_en_i;
//   DRAIN -> FETCH/IDLE when outstanding reaches 0.
//  Issue (FETCH only): req_o=1 iff outstanding<MaxOutstanding and fifo_count+outstanding<FifoDepth.
//   req_o/addr_o held stable until ready_i; flush may replace addr of an ungranted req next cycle.
//  Grant (req_o & ready_i): outstanding++, addr += DataWidth/8, wraps modulo 2^AddrWidth.
//  Response (valid_i): outstanding--; in FETCH/IDLE push {rdata, pc} to FIFO; in DRAIN or on
//   a flush cycle data is discarded. Grant and response same cycle: outstanding unchanged.
//  Credit rule guarantees FIFO never overflows; valid_i with outstanding==0 is a protocol error
//   (assertion), ignored.
//  Pop: ack_i & new_instr_o removes head. Push and pop same cycle, incl. full: both done, count unchanged.
//  Flush (highest priority): FIFO cleared same edge, addr_o <= flush_addr_i, grant in flush cycle
//   counted outstanding and drained. Flush in DRAIN: target updated, stay in DRAIN.
//  Latency, zero-wait imem (ready=1, valid next cycle): req cycle 0, valid cycle 1, new_instr_o
//   cycle 2. Empty-FIFO bypass not provided.
//  fetch_en_i low: no new requests; in-flight responses still land in FIFO.
//  Reset mid-transaction: all state cleared at once; late imem responses are the system's concern.
// TESTING
//  Reset release, fetch_en=1, zero-wait imem returning addr as data -> addr 0,4,8..., instr_o=pc_o, 1/cycle after cycle 2.
//  Consumer ack=0, FifoDepth=4 -> exactly 4 grants, req_o low, new_instr_o=1; one ack -> one new req.
//  Flush to 0x100 with 2 outstanding -> both responses dropped, busy_o=1 until drained, first push pc=0x100.
//  ready_i held low 5 cycles -> req_o and addr_o stable all 5 cycles; grant on 6th -> addr advances by 4.
//  Push+pop same cycle at full FIFO -> count stays 4, order preserved; addr 0xFFFF_FFFC -> next 0x0.
//  rstn_i low asynchronously mid-burst -> outputs reach reset values before next clock edge.

Source files
------------

// File: rtl/beta_prefetch_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : beta_prefetch_fetch_unit_if
// Description : imem and IF-stage signal bundle for the prefetch fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface beta_prefetch_fetch_unit_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                 if_fu_fetch_en_i;
  logic                 if_fu_flush_i;
  logic [AddrWidth-1:0] if_fu_flush_addr_i;
  logic                 if_fu_instr_req_o;
  logic [AddrWidth-1:0] if_fu_instr_addr_o;
  logic                 if_fu_instr_ready_i;
  logic                 if_fu_instr_valid_i;
  logic [DataWidth-1:0] if_fu_instr_rdata_i;
  logic [DataWidth-1:0] if_fu_instr_o;
  logic [AddrWidth-1:0] if_fu_instr_pc_o;
  logic                 if_fu_new_instr_o;
  logic                 if_fu_instr_ack_i;
  logic                 if_fu_stage_busy_o;

  // The fetch unit itself
  modport master (
    input  if_fu_fetch_en_i, if_fu_flush_i, if_fu_flush_addr_i,
    input  if_fu_instr_ready_i, if_fu_instr_valid_i, if_fu_instr_rdata_i,
    input  if_fu_instr_ack_i,
    output if_fu_instr_req_o, if_fu_instr_addr_o,
    output if_fu_instr_o, if_fu_instr_pc_o, if_fu_new_instr_o, if_fu_stage_busy_o
  );

  // The surrounding imem / IF-stage environment
  modport slave (
    output if_fu_fetch_en_i, if_fu_flush_i, if_fu_flush_addr_i,
    output if_fu_instr_ready_i, if_fu_instr_valid_i, if_fu_instr_rdata_i,
    output if_fu_instr_ack_i,
    input  if_fu_instr_req_o, if_fu_instr_addr_o,
    input  if_fu_instr_o, if_fu_instr_pc_o, if_fu_new_instr_o, if_fu_stage_busy_o
  );
endinterface
`default_nettype wire

// File: rtl/beta_prefetch_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : beta_prefetch_fetch_unit
// Description : Pipelined sequential fetch with credit-limited prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_prefetch_fetch_unit #(
  parameter int                   DataWidth      = 32,
  parameter int                   AddrWidth      = 32,
  parameter int                   FifoDepth      = 4,
  parameter int                   MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] BootAddr       = '0
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  beta_prefetch_fetch_unit_if.master  bus
);

  localparam int c_step  = DataWidth / 8;
  localparam int c_ptr_w = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int c_cnt_w = $clog2(FifoDepth + 1);
  localparam int c_out_w = $clog2(MaxOutstanding + 1);
  localparam int c_sum_w = c_cnt_w + 1;
  localparam logic [DataWidth-1:0] c_nop = DataWidth'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [AddrWidth-1:0] r_addr;
  logic [c_out_w-1:0]   r_outstanding;
  logic [c_out_w-1:0]   w_out_next;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [DataWidth-1:0] r_fifo_data [FifoDepth];
  logic [AddrWidth-1:0] r_fifo_pc   [FifoDepth];

  logic                 w_req, w_grant, w_resp, w_push, w_pop, w_empty;
  logic [c_sum_w-1:0]   w_inflight;
  logic [AddrWidth-1:0] w_resp_pc;

  // Credits cover both buffered and in-flight words, so a push never finds the FIFO full.
  assign w_inflight = c_sum_w'(r_count) + c_sum_w'(r_outstanding);
  assign w_req      = (r_state == ST_FETCH)
                   && (r_outstanding < c_out_w'(MaxOutstanding))
                   && (w_inflight < c_sum_w'(FifoDepth));
  assign w_grant    = w_req & bus.if_fu_instr_ready_i;
  assign w_resp     = bus.if_fu_instr_valid_i & (r_outstanding != '0);
  assign w_out_next = r_outstanding + c_out_w'(w_grant) - c_out_w'(w_resp);
  assign w_empty    = (r_count == '0);
  assign w_pop      = bus.if_fu_instr_ack_i & ~w_empty;
  assign w_push     = w_resp & ~bus.if_fu_flush_i & (r_state != ST_DRAIN);

  // Requests of one run are contiguous, so the oldest in-flight pc trails r_addr.
  assign w_resp_pc  = r_addr - AddrWidth'(r_outstanding) * AddrWidth'(c_step);

  always_comb begin
    w_state_next = r_state;
    if (bus.if_fu_flush_i) begin
      if (w_out_next != '0)          w_state_next = ST_DRAIN;
      else if (bus.if_fu_fetch_en_i) w_state_next = ST_FETCH;
      else                           w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.if_fu_fetch_en_i) w_state_next = ST_FETCH;
        ST_FETCH: if (!bus.if_fu_fetch_en_i && !(w_req && !bus.if_fu_instr_ready_i))
                    w_state_next = ST_IDLE;
        ST_DRAIN: if (w_out_next == '0)
                    w_state_next = bus.if_fu_fetch_en_i ? ST_FETCH : ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= ST_IDLE;
      r_addr        <= BootAddr;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      if (bus.if_fu_flush_i)
        r_addr <= bus.if_fu_flush_addr_i;
      else if (w_grant)
        r_addr <= r_addr + AddrWidth'(c_step);
      if (bus.if_fu_flush_i) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= bus.if_fu_instr_rdata_i;
      r_fifo_pc[r_wr_ptr]   <= w_resp_pc;
    end
  end

  assign bus.if_fu_instr_req_o  = w_req;
  assign bus.if_fu_instr_addr_o = r_addr;
  assign bus.if_fu_new_instr_o  = ~w_empty;
  assign bus.if_fu_instr_o      = w_empty ? c_nop : r_fifo_data[r_rd_ptr];
  assign bus.if_fu_instr_pc_o   = w_empty ? '0    : r_fifo_pc[r_rd_ptr];
  assign bus.if_fu_stage_busy_o = (r_outstanding != '0) || (r_state == ST_DRAIN);

  a_no_orphan_response: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    bus.if_fu_instr_valid_i |-> (r_outstanding != '0)
  );

endmodule
`default_nettype wire

// File: tb/tb_beta_prefetch_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_beta_prefetch_fetch_unit
// Description : Directed vector bench with a queued imem responder (data = addr).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beta_prefetch_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;

  beta_prefetch_fetch_unit_if #(.DataWidth(32), .AddrWidth(32)) bus ();

  beta_prefetch_fetch_unit #(
    .DataWidth(32), .AddrWidth(32), .FifoDepth(4), .MaxOutstanding(2), .BootAddr(32'h0)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst, fen, fl;
    logic [31:0] faddr;
    bit          rdy, rsp, ack;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_nv;
    logic [31:0] e_instr, e_pc;
    bit          e_busy;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] imem_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic add(input bit rst, fen, fl, input logic [31:0] faddr,
                     input bit rdy, rsp, ack,
                     input bit req, input logic [31:0] addr, input bit nv,
                     input logic [31:0] instr, pc, input bit busy);
    vec_t v;
    v.rst = rst; v.fen = fen; v.fl = fl; v.faddr = faddr;
    v.rdy = rdy; v.rsp = rsp; v.ack = ack;
    v.e_req = req; v.e_addr = addr; v.e_nv = nv;
    v.e_instr = instr; v.e_pc = pc; v.e_busy = busy;
    vecs.push_back(v);
  endtask

  // One clock cycle: drive at negedge, check 1ns later, update the imem model at posedge.
  task automatic apply(input vec_t v, input string tag);
    bit          vld, grant;
    logic [31:0] gaddr;
    @(negedge clk_i);
    rstn_i = !v.rst;
    if (v.rst) imem_q.delete();
    vld = !v.rst && v.rsp && (imem_q.size() > 0);
    bus.if_fu_instr_valid_i = vld;
    bus.if_fu_instr_rdata_i = vld ? imem_q[0] : 32'h0;
    bus.if_fu_fetch_en_i    = v.fen;
    bus.if_fu_flush_i       = v.fl;
    bus.if_fu_flush_addr_i  = v.faddr;
    bus.if_fu_instr_ready_i = v.rdy;
    bus.if_fu_instr_ack_i   = v.ack;
    #1;
    n_vec++;
    if (bus.if_fu_instr_req_o !== v.e_req || bus.if_fu_instr_addr_o !== v.e_addr ||
        bus.if_fu_new_instr_o !== v.e_nv || bus.if_fu_instr_o !== v.e_instr ||
        bus.if_fu_instr_pc_o !== v.e_pc || bus.if_fu_stage_busy_o !== v.e_busy) begin
      n_bad++;
      $display("FAIL %s: got req=%0b addr=%h nv=%0b instr=%h pc=%h busy=%0b; want req=%0b addr=%h nv=%0b instr=%h pc=%h busy=%0b",
               tag, bus.if_fu_instr_req_o, bus.if_fu_instr_addr_o, bus.if_fu_new_instr_o,
               bus.if_fu_instr_o, bus.if_fu_instr_pc_o, bus.if_fu_stage_busy_o,
               v.e_req, v.e_addr, v.e_nv, v.e_instr, v.e_pc, v.e_busy);
    end
    grant = !v.rst && bus.if_fu_instr_req_o && v.rdy;
    gaddr = bus.if_fu_instr_addr_o;
    @(posedge clk_i);
    if (vld)   void'(imem_q.pop_front());
    if (grant) imem_q.push_back(gaddr);
  endtask

  task automatic run_all(input string prefix);
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("%s%0d", prefix, i));
    vecs.delete();
  endtask

  initial begin
    bus.if_fu_fetch_en_i    = 1'b0;
    bus.if_fu_flush_i       = 1'b0;
    bus.if_fu_flush_addr_i  = 32'h0;
    bus.if_fu_instr_ready_i = 1'b0;
    bus.if_fu_instr_valid_i = 1'b0;
    bus.if_fu_instr_rdata_i = 32'h0;
    bus.if_fu_instr_ack_i   = 1'b0;

    //   rst fen fl faddr         rdy rsp ack | req addr          nv instr         pc            busy
    // Reset, then zero-wait streaming at 1 instr/cycle
    add(1, 0, 0, 32'h0,          0, 0, 0,   0, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 1, 1,   0, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h4,         0, NOP,          32'h0,        1);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h8,         1, 32'h0,        32'h0,        1);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'hC,         1, 32'h4,        32'h4,        1);
    // Consumer stalls: FIFO fills to 4 and requests stop
    add(0, 1, 0, 32'h0,          1, 1, 0,   1, 32'h10,        1, 32'h8,        32'h8,        1);
    add(0, 1, 0, 32'h0,          1, 1, 0,   1, 32'h14,        1, 32'h8,        32'h8,        1);
    add(0, 1, 0, 32'h0,          1, 1, 0,   0, 32'h18,        1, 32'h8,        32'h8,        1);
    add(0, 1, 0, 32'h0,          1, 1, 0,   0, 32'h18,        1, 32'h8,        32'h8,        0);
    // Single pop releases exactly one request
    add(0, 1, 0, 32'h0,          1, 1, 1,   0, 32'h18,        1, 32'h8,        32'h8,        0);
    add(0, 1, 0, 32'h0,          1, 1, 0,   1, 32'h18,        1, 32'hC,        32'hC,        0);
    add(0, 1, 0, 32'h0,          1, 1, 0,   0, 32'h1C,        1, 32'hC,        32'hC,        1);
    add(0, 1, 0, 32'h0,          1, 1, 0,   0, 32'h1C,        1, 32'hC,        32'hC,        0);
    // Async reset with a full FIFO
    add(1, 1, 0, 32'h0,          1, 1, 0,   0, 32'h0,         0, NOP,          32'h0,        0);
    // ready held low for 5 request cycles, grant on the 6th
    add(0, 1, 0, 32'h0,          0, 1, 1,   0, 32'h0,         0, NOP,          32'h0,        0);
    for (int k = 0; k < 5; k++)
      add(0, 1, 0, 32'h0,        0, 1, 1,   1, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          0, 1, 1,   1, 32'h4,         0, NOP,          32'h0,        1);
    // Flush with nothing in flight to the top of the address space, then wrap
    add(0, 1, 1, 32'hFFFF_FFFC,  0, 1, 1,   1, 32'h4,         1, 32'h0,        32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'hFFFF_FFFC, 0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h0,         0, NOP,          32'h0,        1);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h4,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h8,         1, 32'h0,        32'h0,        1);
    // Two in flight, flush to 0x100: both responses dropped, then restart
    add(1, 1, 0, 32'h0,          1, 0, 1,   0, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 0, 1,   0, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 0, 1,   1, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 0, 1,   1, 32'h4,         0, NOP,          32'h0,        1);
    add(0, 1, 1, 32'h100,        1, 1, 1,   0, 32'h8,         0, NOP,          32'h0,        1);
    add(0, 1, 0, 32'h0,          1, 1, 1,   0, 32'h100,       0, NOP,          32'h0,        1);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h100,       0, NOP,          32'h0,        0);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h104,       0, NOP,          32'h0,        1);
    add(0, 1, 0, 32'h0,          1, 1, 1,   1, 32'h108,       1, 32'h100,      32'h100,      1);
    // Async reset mid-burst, then idle with fetch disabled
    add(1, 1, 0, 32'h0,          1, 1, 1,   0, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 0, 0, 32'h0,          1, 1, 0,   0, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 0, 0, 32'h0,          1, 1, 0,   0, 32'h0,         0, NOP,          32'h0,        0);
    run_all("vec");

    // fetch_en drops on a granted request: unit idles, the response still lands; empty ack ignored
    add(0, 1, 0, 32'h0,          1, 0, 1,   0, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 0, 0, 32'h0,          1, 0, 0,   1, 32'h0,         0, NOP,          32'h0,        0);
    add(0, 0, 0, 32'h0,          1, 1, 0,   0, 32'h4,         0, NOP,          32'h0,        1);
    add(0, 0, 0, 32'h0,          1, 0, 0,   0, 32'h4,         1, 32'h0,        32'h0,        0);
    add(0, 0, 0, 32'h0,          1, 0, 1,   0, 32'h4,         1, 32'h0,        32'h0,        0);
    add(0, 0, 0, 32'h0,          1, 0, 1,   0, 32'h4,         0, NOP,          32'h0,        0);
    add(0, 0, 0, 32'h0,          1, 0, 0,   0, 32'h4,         0, NOP,          32'h0,        0);
    run_all("seq_fen_off");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
